// File: rtl/booth_r4_hi_datapath.sv
// Radix-4 Booth sequencer and HI-half accumulator; drives a 2-bit-per-cycle LO shifter
// so that {hi_out, LO} holds the signed product after tamano/2 CALC cycles.
module booth_r4_hi_datapath #(
    parameter int tamano = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    input  logic [tamano-1:0] multiplicand,
    input  logic [1:0]        lo_bits_in,
    output logic [1:0]        lo_bits_out,
    output logic              lo_mode,
    output logic              lo_enable,
    output logic [tamano-1:0] hi_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: start is accepted only on an edge where the FSM is IDLE; the
    // result is valid during the single cycle done=1, and busy covers LOAD..CALC.
    localparam int AW = tamano + 2;
    localparam int CW = $clog2(tamano / 2) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(tamano / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [tamano-1:0]      m_q, m_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic                   q_prev_q, q_prev_d;
    logic [CW-1:0]          count_q, count_d;

    logic signed [AW-1:0]   m_ext;
    logic signed [AW-1:0]   pp;
    logic signed [AW-1:0]   sum;

    // Two guard bits keep +/-2M exact even for M = -2^(tamano-1).
    always_comb begin
        m_ext = {{2{m_q[tamano-1]}}, m_q};
        pp    = '0;
        case ({lo_bits_in, q_prev_q})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext <<< 1;
            3'b100:         pp = -(m_ext <<< 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        sum = acc_q + pp;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            acc_q    <= '0;
            q_prev_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            q_prev_q <= q_prev_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_prev_d = q_prev_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d      = multiplicand;
                    acc_d    = '0;
                    q_prev_d = 1'b0;
                    count_d  = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: state_d = S_CALC;
            S_CALC: begin
                // The two bits dropped here travel into the top of LO via lo_bits_out.
                acc_d    = sum >>> 2;
                q_prev_d = lo_bits_in[1];
                count_d  = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lo_bits_out = 2'b00;
        lo_mode     = 1'b0;
        lo_enable   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_LOAD: begin
                lo_mode   = 1'b1;
                lo_enable = 1'b1;
                busy      = 1'b1;
            end
            S_CALC: begin
                lo_bits_out = sum[1:0];
                lo_enable   = 1'b1;
                busy        = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign hi_out    = acc_q[tamano-1:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_r4_hi_datapath.sv
// Randomized bench for booth_r4_hi_datapath with a behavioural LO shifter and a
// scoreboard fed from plain signed multiplication.
module tb_booth_r4_hi_datapath;
    localparam int W    = 8;
    localparam int HALF = W / 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic         start;
    logic [W-1:0] multiplicand;
    logic [1:0]   lo_bits_in;
    logic [1:0]   lo_bits_out;
    logic         lo_mode;
    logic         lo_enable;
    logic [W-1:0] hi_out;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    logic [W-1:0] q_par;
    logic [W-1:0] lo_q = '0;
    logic         mon_en;

    logic [1:0]     exp_bits_q[$];
    logic [2*W-1:0] exp_prod_q[$];
    int errors = 0;
    int checks = 0;

    booth_r4_hi_datapath #(.tamano(W)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .start       (start),
        .multiplicand(multiplicand),
        .lo_bits_in  (lo_bits_in),
        .lo_bits_out (lo_bits_out),
        .lo_mode     (lo_mode),
        .lo_enable   (lo_enable),
        .hi_out      (hi_out),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    always #5 CLOCK = ~CLOCK;

    // LO shifter: parallel load, or shift right by two with serial input at the top.
    always @(posedge CLOCK) begin
        if (lo_enable) begin
            if (lo_mode) lo_q <= q_par;
            else         lo_q <= {lo_bits_out, lo_q[W-1:2]};
        end
    end
    assign lo_bits_in = lo_q[1:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents shifter bits or a result.
    always @(negedge CLOCK) begin
        if (mon_en && RESET) begin
            if (lo_enable && !lo_mode) begin
                if (exp_bits_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL lo_bits_seq: got 0x%0h expected no CALC cycle", lo_bits_out);
                end else begin
                    check("lo_bits_seq", 64'(lo_bits_out), 64'(exp_bits_q.pop_front()));
                end
            end
            if (done) begin
                if (exp_prod_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL product: got 0x%0h expected no done", {hi_out, lo_q});
                end else begin
                    check("product", 64'({hi_out, lo_q}), 64'(exp_prod_q.pop_front()));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hi_out"},   64'(hi_out),      64'(0));
        check({tag, "_lo_bits"},  64'(lo_bits_out), 64'(0));
        check({tag, "_lo_mode"},  64'(lo_mode),     64'(0));
        check({tag, "_lo_en"},    64'(lo_enable),   64'(0));
        check({tag, "_busy"},     64'(busy),        64'(0));
        check({tag, "_done"},     64'(done),        64'(0));
        check({tag, "_state"},    64'(dbg_state),   64'(ST_IDLE));
    endtask

    // Driver: caller is in IDLE, #1 after an edge. keep holds start high; poke pulses it in CALC.
    task automatic do_mul(input logic [W-1:0] m, input logic [W-1:0] q, input bit keep, input bit poke);
        longint         p;
        logic [2*W-1:0] pv;
        int             cyc;
        p  = longint'($signed(m)) * longint'($signed(q));
        pv = p[2*W-1:0];
        exp_prod_q.push_back(pv);
        for (int k = 0; k < HALF; k++) exp_bits_q.push_back(pv[2*k +: 2]);
        multiplicand = m;
        q_par        = q;
        start        = 1'b1;
        @(posedge CLOCK); #1;
        check("accept_state", 64'(dbg_state), 64'(ST_LOAD));
        check("load_busy",    64'(busy),      64'(1));
        multiplicand = W'($urandom);
        cyc = 0;
        while (!done && cyc < HALF + 8) begin
            start = (poke && cyc == 2) ? 1'b1 : keep;
            @(posedge CLOCK); #1;
            cyc++;
            if (cyc == 1) q_par = W'($urandom);
        end
        check("latency", 64'(cyc), 64'(HALF + 1));
        check("done_seen", 64'(done), 64'(1));
        start = keep;
        @(posedge CLOCK); #1;
        check("done_pulse", 64'(done),      64'(0));
        check("back_idle",  64'(dbg_state), 64'(ST_IDLE));
        check("hi_hold",    64'(hi_out),    64'(pv[2*W-1:W]));
    endtask

    initial begin
        RESET = 1'b0; start = 1'b0; multiplicand = '0; q_par = '0; mon_en = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset_outputs("por");
        @(negedge CLOCK); RESET = 1'b1;
        @(posedge CLOCK); #1;

        do_mul(8'd7,   8'd3,   1'b0, 1'b0);
        do_mul(8'hFF,  8'h01,  1'b0, 1'b0);
        do_mul(8'h80,  8'h80,  1'b0, 1'b0);
        do_mul(8'd127, 8'h80,  1'b0, 1'b0);

        // Abort mid-CALC: outputs must clear in the same cycle with no done pulse.
        mon_en = 1'b0;
        multiplicand = 8'h35; q_par = 8'h5A; start = 1'b1;
        @(posedge CLOCK); #1; start = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("abort_in_calc", 64'(dbg_state), 64'(ST_CALC));
        RESET = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge CLOCK); RESET = 1'b1;
        @(posedge CLOCK); #1;
        check("abort_no_done", 64'(done), 64'(0));
        mon_en = 1'b1;

        do_mul(8'h5A, 8'hC3, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) do_mul(W'($urandom), W'($urandom), 1'b1, 1'b0);
        start = 1'b0;
        @(posedge CLOCK); #1;

        for (int j = 0; j < 3000; j++) begin
            logic [W-1:0] m, q;
            m = ($urandom_range(0, 15) == 0) ? 8'h80 : W'($urandom);
            q = ($urandom_range(0, 15) == 0) ? 8'h80 : W'($urandom);
            do_mul(m, q, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        start = 1'b0;
        repeat (4) @(posedge CLOCK);
        #1;
        check("bits_drained", 64'(exp_bits_q.size()), 64'(0));
        check("prod_drained", 64'(exp_prod_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
